// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Issues instruction-bus fetches for the current PC and presents
//             {pc, instr} to decode over a valid/ready handshake.
//  Options  : FETCH_ALIGN_CHECK_EN - misaligned PCs become a flagged NOP
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN      = 64,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [ILEN-1:0] iresp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
    output logic            if_misalign,
    input  logic            id_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            issued_q, issued_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= 1'b0;
            addr_q     <= '0;
            if_pc_q    <= '0;
            instr_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            addr_q     <= addr_d;
            if_pc_q    <= if_pc_d;
            instr_q    <= instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // REQ spends its first cycle latching pc (issued_q=0); the bus request
    // is only raised once the address is registered and cannot move.
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        addr_d     = addr_q;
        if_pc_d    = if_pc_q;
        instr_d    = instr_q;
        pc_en      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                state_d  = REQ;
                issued_d = 1'b0;
            end
            REQ: begin
                if (!issued_q) begin
                    if (flush) begin
                        pc_en = 1'b1;
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    else if (pc[1:0] != 2'b00) begin
                        state_d    = HOLD;
                        if_pc_d    = pc;
                        instr_d    = NOP_INSTR;
                        misalign_d = 1'b1;
                    end
`endif
                    else begin
                        addr_d   = pc;
                        issued_d = 1'b1;
                    end
                end else if (iresp_data_ok) begin
                    issued_d = 1'b0;
                    if (flush) begin
                        pc_en = 1'b1;
                    end else begin
                        state_d = HOLD;
                        if_pc_d = addr_q;
                        instr_d = iresp_data;
                    end
                end else if (flush) begin
                    // Bus has no cancel: keep the request up and drop its data.
                    state_d  = DROP;
                    issued_d = 1'b0;
                end
            end
            HOLD: begin
                if (flush || id_ready) begin
                    pc_en    = 1'b1;
                    state_d  = REQ;
                    issued_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            DROP: begin
                if (iresp_data_ok) begin
                    pc_en   = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ireq_valid = ((state_q == REQ) && issued_q) || (state_q == DROP);
    assign ireq_addr  = addr_q;
    assign if_valid   = (state_q == HOLD);
    assign if_pc      = if_pc_q;
    assign if_instr   = instr_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign if_misalign = misalign_q;
`else
    assign if_misalign = 1'b0;
    logic unused_nop;
    assign unused_nop = ^NOP_INSTR;
`endif

`ifndef SYNTHESIS
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (ireq_valid && $past(ireq_valid)) |-> $stable(ireq_addr));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Cycle-table and directed-sequence bench for fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [63:0] P0 = 64'h8000_0000;
    localparam logic [63:0] P1 = 64'h8000_0004;
    localparam logic [63:0] P2 = 64'h8000_0008;
    localparam logic [63:0] T1 = 64'h8000_0100;
    localparam logic [63:0] T2 = 64'h8000_0200;
    localparam logic [63:0] T3 = 64'h8000_0300;
    localparam logic [63:0] PM = 64'h8000_0002;
    localparam logic [31:0] I0 = 32'h0000_0093;
    localparam logic [31:0] I1 = 32'h0000_0113;
    localparam logic [31:0] I2 = 32'h0000_0193;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] BD = 32'h0BAD_0013;
    localparam int          NV = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc = P0;
    logic        flush = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        id_ready = 1'b0;
    logic        pc_en, ireq_valid, if_valid, if_misalign;
    logic [63:0] ireq_addr, if_pc;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_en        (pc_en),
        .flush        (flush),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_misalign  (if_misalign),
        .id_ready     (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        flush;
        logic        ok;
        logic [31:0] data;
        logic        rdy;
        logic        e_pcen;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_ifv;
        logic [63:0] e_ifpc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [63:0] p, input logic f, input logic ok,
                                input logic [31:0] d, input logic r, input logic epe,
                                input logic erv, input logic [63:0] ea, input logic eiv,
                                input logic [63:0] eip, input logic [31:0] ein);
        vec_t v;
        v.pc = p; v.flush = f; v.ok = ok; v.data = d; v.rdy = r;
        v.e_pcen = epe; v.e_rv = erv; v.e_addr = ea; v.e_ifv = eiv;
        v.e_ifpc = eip; v.e_instr = ein;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic epe, input logic erv,
                           input logic [63:0] ea, input logic eiv,
                           input logic [63:0] eip, input logic [31:0] ein,
                           input logic emis);
        chk("pc_en",       idx, 64'(pc_en),       64'(epe));
        chk("ireq_valid",  idx, 64'(ireq_valid),  64'(erv));
        chk("ireq_addr",   idx, ireq_addr,        ea);
        chk("if_valid",    idx, 64'(if_valid),    64'(eiv));
        chk("if_pc",       idx, if_pc,            eip);
        chk("if_instr",    idx, 64'(if_instr),    64'(ein));
        chk("if_misalign", idx, 64'(if_misalign), 64'(emis));
    endtask

    initial begin
        //               pc  fl ok data rdy  pcen rv  addr ifv ifpc instr
        vecs[0]  = mk(P0, 0, 0, '0, 1,  0, 0, '0, 0, '0, '0);
        vecs[1]  = mk(P0, 0, 0, '0, 1,  0, 0, '0, 0, '0, '0);
        vecs[2]  = mk(P0, 0, 0, '0, 1,  0, 1, P0, 0, '0, '0);
        vecs[3]  = mk(P0, 0, 0, '0, 1,  0, 1, P0, 0, '0, '0);
        vecs[4]  = mk(P0, 0, 1, I0, 1,  0, 1, P0, 0, '0, '0);
        vecs[5]  = mk(P0, 0, 0, '0, 1,  1, 0, P0, 1, P0, I0);
        vecs[6]  = mk(P1, 0, 0, '0, 1,  0, 0, P0, 0, P0, I0);
        vecs[7]  = mk(P1, 0, 1, I1, 0,  0, 1, P1, 0, P0, I0);
        for (int i = 8; i <= 12; i++)
            vecs[i] = mk(P1, 0, 0, '0, 0,  0, 0, P1, 1, P1, I1);
        vecs[13] = mk(P1, 0, 0, '0, 1,  1, 0, P1, 1, P1, I1);
        vecs[14] = mk(P2, 0, 0, '0, 1,  0, 0, P1, 0, P1, I1);
        vecs[15] = mk(P2, 1, 0, '0, 1,  0, 1, P2, 0, P1, I1);
        vecs[16] = mk(P2, 0, 0, '0, 1,  0, 1, P2, 0, P1, I1);
        vecs[17] = mk(P2, 0, 0, '0, 1,  0, 1, P2, 0, P1, I1);
        vecs[18] = mk(P2, 0, 1, DB, 1,  1, 1, P2, 0, P1, I1);
        vecs[19] = mk(T1, 0, 0, '0, 1,  0, 0, P2, 0, P1, I1);
        vecs[20] = mk(T1, 0, 1, I2, 1,  0, 1, T1, 0, P1, I1);
        vecs[21] = mk(T1, 1, 0, '0, 1,  1, 0, T1, 1, T1, I2);
        vecs[22] = mk(T2, 0, 0, '0, 1,  0, 0, T1, 0, T1, I2);
        vecs[23] = mk(T2, 1, 1, BD, 1,  1, 1, T2, 0, T1, I2);
        vecs[24] = mk(T3, 0, 0, '0, 1,  0, 0, T2, 0, T1, I2);
        vecs[25] = mk(T3, 0, 0, '0, 1,  0, 1, T3, 0, T1, I2);

        // Reset state while rst is held
        #12;
        chk_all(100, 0, 0, '0, 0, '0, '0, 0);

        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            pc            = vecs[i].pc;
            flush         = vecs[i].flush;
            iresp_data_ok = vecs[i].ok;
            iresp_data    = vecs[i].data;
            id_ready      = vecs[i].rdy;
            @(negedge clk);
            chk_all(i, vecs[i].e_pcen, vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_ifv,
                    vecs[i].e_ifpc, vecs[i].e_instr, 0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while a request is outstanding
        #2 rst = 1'b1;
        #1;
        chk_all(200, 0, 0, '0, 0, '0, '0, 0);
        pc = PM;
        id_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all(201, 0, 0, '0, 0, '0, '0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all(202, 0, 0, '0, 0, '0, '0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        chk_all(203, 1, 0, '0, 1, PM, 32'h0000_0013, 1);
        @(posedge clk);
        #1 pc = P0;
        @(negedge clk);
        chk_all(204, 0, 0, '0, 0, PM, 32'h0000_0013, 0);
`else
        chk_all(203, 0, 1, PM, 0, '0, '0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all(204, 0, 1, PM, 0, '0, '0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
